// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one imem read at a time, holds the returned word
// for decode, and advances the PC (sequential, jump/branch target, or halt).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   REQ   | request outstanding on imem_req_*, address = pc
//   WAIT  | request accepted, waiting for imem_resp_valid
//   HOLD  | instruction held on instr/instr_pc until instr_ready
//   HALT  | halt instruction consumed; fetch stopped until rst
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,

  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,

  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,

  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        halted,
  output logic        fetch_halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        capture;
  logic        accept;
  logic        req_valid_c;
  logic        instr_valid_c;
  logic        halted_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC_ALIGNED;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        instr    <= imem_resp_data;
        instr_pc <= pc;
      end
      if (accept) begin
        pc          <= pc_nxt;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // Control inputs are only meaningful in the accept cycle; elsewhere pc_nxt is unused.
  assign pc_nxt = pc_src ? (pc_target & ~32'h3) : (pc + 32'd4);

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    accept        = 1'b0;
    req_valid_c   = 1'b0;
    instr_valid_c = 1'b0;
    halted_c      = 1'b0;
    case (state)
      S_REQ: begin
        req_valid_c = 1'b1;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid_c = 1'b1;
        if (instr_ready) begin
          accept    = 1'b1;
          state_nxt = halted ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Handshake outputs are forced low while rst is asserted, whatever state is held.
  assign imem_req_valid = req_valid_c & ~rst;
  assign instr_valid    = instr_valid_c & ~rst;
  assign fetch_halted   = halted_c & ~rst;
  assign imem_req_addr  = pc;
  assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset (bits [1:0] zero).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  SHALL flag an instruction-memory read request.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-006 imem_req_addr  output  32  SHALL carry the fetch address (current PC).
REQ-007 imem_resp_valid  input  1  SHALL flag that read data is valid this cycle.
REQ-008 imem_resp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 instr_valid  output  1  SHALL flag a held instruction for decode/control.
REQ-010 instr_ready  input  1  SHALL flag that the decode/execute stage consumes the held instruction this cycle.
REQ-011 instr  output  32  SHALL carry the held instruction word.
REQ-012 instr_pc  output  32  SHALL carry the address of the held instruction.
REQ-013 instr_pc_plus4  output  32  SHALL carry instr_pc + 4, modulo 2^32.
REQ-014 pc_src  input  1  SHALL select pc_target as the next PC (jump or taken branch from the control unit).
REQ-015 pc_target  input  32  SHALL carry the branch/jump target address.
REQ-016 halted  input  1  SHALL flag that the held instruction is a halt.
REQ-017 fetch_halted  output  1  SHALL flag that fetch has stopped permanently.
REQ-018 fetch_count  output  32  SHALL count consumed instructions.

Function
REQ-019 The FSM SHALL have states REQ, WAIT, HOLD, HALT.
REQ-020 REQ: imem_req_valid=1 and imem_req_addr=pc; if imem_req_ready=1 -> WAIT, else stay with address stable.
REQ-021 WAIT: imem_req_valid=0; if imem_resp_valid=1, capture imem_resp_data into instr -> HOLD, else stay.
REQ-022 HOLD: instr_valid=1 with instr/instr_pc stable; if instr_ready=0, stay.
REQ-023 HOLD with instr_ready=1: fetch_count += 1 (wraps at 2^32); pc <= pc_src ? {pc_target[31:2],2'b00} : pc+4; then -> HALT if halted=1, else -> REQ.
REQ-024 pc_src, pc_target and halted SHALL be sampled only in the HOLD cycle with instr_ready=1 and ignored otherwise.
REQ-025 If halted=1 and pc_src=1 in the same accept cycle, pc SHALL still update, and the FSM SHALL enter HALT.
REQ-026 HALT: imem_req_valid=0, instr_valid=0, fetch_halted=1; exit only via rst.
REQ-027 imem_resp_valid SHALL be ignored in REQ, HOLD and HALT.
REQ-028 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-029 Minimum latency: request accepted in cycle N, response in N+1, instr_valid in N+2; with instr_ready=1, the next request is issued in N+3.
REQ-030 instr_valid SHALL be 1 only in HOLD.

Reset
REQ-031 rst=1 SHALL force state REQ, pc=RESET_PC, instr=0, instr_pc=0, fetch_count=0, fetch_halted=0, instr_valid=0, imem_req_valid=0 during the reset cycle.
REQ-032 rst asserted in any state, including WAIT with an outstanding request, SHALL abandon that state.
REQ-033 A response that arrives after reset while the FSM is in REQ SHALL be discarded.

Verification
REQ-034 Sequential fetch: reset, 0-wait memory, instr_ready=1, pc_src=0 -> addresses 0,4,8,12; fetch_count=3 after third accept.
REQ-035 Taken jump: accept at pc=0x10 with pc_src=1, pc_target=0x103 -> next imem_req_addr=0x100.
REQ-036 Backpressure: imem_req_ready low 3 cycles, then instr_ready low 2 cycles -> imem_req_addr, instr and instr_pc held stable; no count change.
REQ-037 Halt: accept with halted=1 -> fetch_halted=1 the next cycle; no further imem_req_valid for 20 cycles.
REQ-038 Wrap and reset-mid-op: RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0; rst in WAIT followed by a stale imem_resp_valid=1 -> ignored, and the fetch restarts at RESET_PC.
